// File: rtl/rsa256_pkg.sv
// rtl/rsa256_pkg.sv - UART register map, status bits and host FSM states for the RSA256 host controller
package rsa256_pkg;

  localparam logic [4:0] UART_RX_ADDR     = 5'd0;
  localparam logic [4:0] UART_TX_ADDR     = 5'd4;
  localparam logic [4:0] UART_STATUS_ADDR = 5'd8;

  localparam int RX_OK_BIT = 7;
  localparam int TX_OK_BIT = 6;

  typedef enum logic [2:0] {
    RX_POLL,
    RX_READ,
    START,
    WAIT,
    TX_POLL,
    TX_WRITE
  } host_state_t;

endpackage

// File: rtl/rsa256_avm_access.sv
// rtl/rsa256_avm_access.sv - single Avalon-MM read/write with waitrequest hold and done pulse
module rsa256_avm_access
  import rsa256_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        go,
  input  logic        go_write,
  input  logic [4:0]  go_address,
  input  logic [7:0]  go_wdata,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        done,
  output logic [31:0] rdata
);

  // A request is only launched from idle, so every completed transfer is
  // followed by at least one cycle with both strobes low.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= UART_STATUS_ADDR;
      avm_writedata <= '0;
    end else if (avm_read || avm_write) begin
      if (!avm_waitrequest) begin
        avm_read  <= 1'b0;
        avm_write <= 1'b0;
      end
    end else if (go) begin
      avm_read      <= !go_write;
      avm_write     <= go_write;
      avm_address   <= go_address;
      avm_writedata <= {24'h0, go_wdata};
    end
  end

  assign done  = (avm_read || avm_write) && !avm_waitrequest;
  assign rdata = avm_readdata;

endmodule

// File: rtl/rsa256_host_ctrl.sv
// rtl/rsa256_host_ctrl.sv - loads key/data words from the UART, runs the RSA256 core, returns result bytes
module rsa256_host_ctrl
  import rsa256_pkg::*;
#(
  parameter int W         = 256,
  parameter int OUT_BYTES = 31
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic [4:0]    avm_address,
  output logic          avm_read,
  input  logic [31:0]   avm_readdata,
  output logic          avm_write,
  output logic [31:0]   avm_writedata,
  input  logic          avm_waitrequest,
  output logic          o_core_start,
  output logic [W-1:0]  o_core_x,
  output logic [W-1:0]  o_core_y,
  input  logic [W-1:0]  i_core_x,
  input  logic          i_core_finished
);

  localparam int NBYTES = W / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_RX = CW'(NBYTES - 1);
  localparam logic [CW-1:0] LAST_TX = CW'(OUT_BYTES - 1);

  host_state_t   state, next_state;
  logic [CW-1:0] cnt;
  logic          key_loaded;
  logic [W-1:0]  res_q;
  logic          acc_go, acc_write, acc_done;
  logic [4:0]    acc_address;
  logic [31:0]   acc_rdata;
  logic          unused_bits;

  assign unused_bits = ^{acc_rdata[31:8], res_q};

  rsa256_avm_access u_access (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .go              (acc_go),
    .go_write        (acc_write),
    .go_address      (acc_address),
    .go_wdata        (res_q[8*OUT_BYTES-1 -: 8]),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .done            (acc_done),
    .rdata           (acc_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= RX_POLL;
    else          state <= next_state;
  end

  // The access request follows next_state so the STATUS poll after
  // `finished` is already on the bus in the following cycle.
  always_comb begin
    next_state   = state;
    o_core_start = 1'b0;
    case (state)
      RX_POLL:  if (acc_done && acc_rdata[RX_OK_BIT]) next_state = RX_READ;
      RX_READ:  if (acc_done) next_state = (cnt == LAST_RX && key_loaded) ? START : RX_POLL;
      START: begin
        o_core_start = 1'b1;
        next_state   = WAIT;
      end
      WAIT:     if (i_core_finished) next_state = TX_POLL;
      TX_POLL:  if (acc_done && acc_rdata[TX_OK_BIT]) next_state = TX_WRITE;
      TX_WRITE: if (acc_done) next_state = (cnt == LAST_TX) ? RX_POLL : TX_POLL;
      default:  next_state = RX_POLL;
    endcase

    acc_go      = 1'b1;
    acc_write   = 1'b0;
    acc_address = UART_STATUS_ADDR;
    case (next_state)
      RX_READ:  acc_address = UART_RX_ADDR;
      TX_WRITE: begin
        acc_write   = 1'b1;
        acc_address = UART_TX_ADDR;
      end
      START, WAIT: acc_go = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      key_loaded <= 1'b0;
      o_core_x   <= '0;
      o_core_y   <= '0;
      res_q      <= '0;
    end else begin
      case (state)
        RX_READ: if (acc_done) begin
          if (key_loaded) o_core_x <= {o_core_x[W-9:0], acc_rdata[7:0]};
          else            o_core_y <= {o_core_y[W-9:0], acc_rdata[7:0]};
          if (cnt == LAST_RX) begin
            cnt        <= '0;
            key_loaded <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT: if (i_core_finished) begin
          res_q <= i_core_x;
          cnt   <= '0;
        end
        TX_WRITE: if (acc_done) begin
          res_q <= {res_q[W-9:0], 8'h00};
          cnt   <= (cnt == LAST_TX) ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa256_host_ctrl.sv
// tb/tb_rsa256_host_ctrl.sv - randomized bench with UART/Avalon slave model and stub core
module tb_rsa256_host_ctrl;

  localparam int W         = 256;
  localparam int OUT_BYTES = 31;
  localparam int NB        = W / 8;

  logic          clk;
  logic          rst_n;
  logic [4:0]    avm_address;
  logic          avm_read, avm_write, avm_waitrequest;
  logic [31:0]   avm_readdata, avm_writedata;
  logic          core_start, core_finished;
  logic [W-1:0]  core_x_out, core_y_out, core_res;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  int ws_max = 0, rx_hold_cfg = 0, tx_hold_cfg = 0, spur_req = 0;
  bit core_auto = 1'b1;
  logic [7:0] rx_buf [0:1023];
  int rx_wr = 0;

  int rx_rd = 0, tx_cnt = 0, status_reads = 0, prot_err = 0, last_rx_cyc = -10;
  logic [7:0] tx_buf [0:1023];
  bit s_busy = 0, s_just_done = 0, s_cap_rd, s_cap_wr, s_rx_ok, s_tx_ok;
  int s_stall = 0, s_rx_hold = 0, s_tx_hold = 0;
  logic [4:0]  s_cap_addr;
  logic [31:0] s_cap_wd, s_rnd;

  int start_cnt = 0, core_err = 0, c_dly = 0, c_spur_done = 0;
  bit c_pend = 0, c_prev_start = 0, c_real_fin = 0;
  logic [W-1:0] c_cap_x, c_cap_y;

  rsa256_host_ctrl #(.W(W), .OUT_BYTES(OUT_BYTES)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .o_core_start    (core_start),
    .o_core_x        (core_x_out),
    .o_core_y        (core_y_out),
    .i_core_x        (core_res),
    .i_core_finished (core_finished)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // UART behind an Avalon slave: random stalls, status holds, protocol watch
  initial begin
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_busy = 0; s_just_done = 0; s_stall = 0;
        avm_waitrequest = 1'b0;
      end else begin
        if (avm_read && avm_write) prot_err++;
        if (s_just_done && (avm_read || avm_write)) prot_err++;
        s_just_done = 0;
        s_rnd = $urandom;
        if (avm_read || avm_write) begin
          if (!s_busy) begin
            s_busy = 1; s_cap_addr = avm_address; s_cap_rd = avm_read;
            s_cap_wr = avm_write; s_cap_wd = avm_writedata;
            s_stall = (ws_max > 0) ? int'($urandom_range(ws_max, 0)) : 0;
          end else if (avm_address !== s_cap_addr || avm_read !== s_cap_rd ||
                       avm_write !== s_cap_wr || (s_cap_wr && avm_writedata !== s_cap_wd)) begin
            prot_err++;
          end
          if (s_stall > 0) begin
            s_stall--;
            avm_waitrequest = 1'b1;
            avm_readdata    = s_rnd;
          end else begin
            avm_waitrequest = 1'b0;
            s_busy = 0; s_just_done = 1;
            if (avm_read && avm_address == 5'd8) begin
              status_reads++;
              s_rx_ok = (rx_rd < rx_wr) && (s_rx_hold == 0);
              s_tx_ok = (s_tx_hold == 0);
              if (s_rx_hold > 0) s_rx_hold--;
              if (s_tx_hold > 0) s_tx_hold--;
              avm_readdata = {s_rnd[31:8], s_rx_ok, s_tx_ok, s_rnd[5:0]};
            end else if (avm_read && avm_address == 5'd0) begin
              if (rx_rd < rx_wr) begin
                avm_readdata = {s_rnd[31:8], rx_buf[rx_rd]};
                rx_rd++;
              end else begin
                prot_err++;
                avm_readdata = s_rnd;
              end
              s_rx_hold   = rx_hold_cfg;
              last_rx_cyc = cyc;
            end else if (avm_write && avm_address == 5'd4) begin
              tx_buf[tx_cnt] = avm_writedata[7:0];
              tx_cnt++;
              s_tx_hold = tx_hold_cfg;
            end else begin
              prot_err++;
            end
          end
        end else begin
          avm_waitrequest = 1'b0;
          avm_readdata    = s_rnd;
        end
      end
    end
  end

  // Stub core: result = x ^ y, five cycles after the start pulse
  initial begin
    core_finished = 1'b0;
    core_res      = '0;
    forever begin
      @(negedge clk);
      if (core_finished) begin
        if (c_real_fin && rst_n && !(avm_read && avm_address == 5'd8)) core_err++;
        core_finished = 1'b0;
      end
      if (!rst_n) begin
        c_pend = 0; c_prev_start = 0;
      end else begin
        if (core_start) begin
          if (c_prev_start) core_err++;
          if (cyc != last_rx_cyc + 1) core_err++;
          start_cnt++;
          c_cap_x = core_x_out; c_cap_y = core_y_out;
          if (core_auto) begin c_pend = 1; c_dly = 5; end
        end else if (c_pend) begin
          if (core_x_out !== c_cap_x || core_y_out !== c_cap_y) core_err++;
          c_dly--;
          if (c_dly == 0) begin
            core_res = c_cap_x ^ c_cap_y; core_finished = 1'b1;
            c_real_fin = 1; c_pend = 0;
          end
        end
        c_prev_start = core_start;
      end
      if (spur_req != c_spur_done) begin
        c_spur_done   = spur_req;
        core_res      = {8{$urandom}};
        core_finished = 1'b1;
        c_real_fin    = 0;
      end
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < NB; i++) begin
      rx_buf[rx_wr] = w[W-1-8*i -: 8];
      rx_wr++;
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W/32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic run_block(input logic [W-1:0] key, input logic [W-1:0] data,
                           input bit send_key, input string name);
    logic [W-1:0] res;
    logic [7:0]   exp_b;
    int base, s0, n;
    base = tx_cnt; s0 = start_cnt; n = 0;
    if (send_key) push_word(key);
    push_word(data);
    while (tx_cnt < base + OUT_BYTES && n < 30000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 30000) begin
      miscompares++;
      $display("FAIL %s timeout: got %0d tx bytes, required %0d", name, tx_cnt - base, OUT_BYTES);
    end
    repeat (40) @(negedge clk);
    res = data ^ key;
    vectors++;
    if (core_y_out !== key) begin
      miscompares++;
      $display("FAIL %s core_y: got %h required %h", name, core_y_out, key);
    end
    vectors++;
    if (core_x_out !== data) begin
      miscompares++;
      $display("FAIL %s core_x: got %h required %h", name, core_x_out, data);
    end
    vectors++;
    if (start_cnt - s0 !== 1) begin
      miscompares++;
      $display("FAIL %s start_pulses: got %0d required 1", name, start_cnt - s0);
    end
    vectors++;
    if (tx_cnt - base !== OUT_BYTES) begin
      miscompares++;
      $display("FAIL %s tx_count: got %0d required %0d", name, tx_cnt - base, OUT_BYTES);
    end
    for (int j = 0; j < OUT_BYTES; j++) begin
      exp_b = res[8*(OUT_BYTES-1-j) +: 8];
      vectors++;
      if (tx_buf[base+j] !== exp_b) begin
        miscompares++;
        $display("FAIL %s tx_byte[%0d]: got %h required %h", name, j, tx_buf[base+j], exp_b);
      end
    end
    vectors++;
    if (prot_err !== 0) begin
      miscompares++;
      $display("FAIL %s avalon_protocol: got %0d violations required 0", name, prot_err);
    end
    vectors++;
    if (core_err !== 0) begin
      miscompares++;
      $display("FAIL %s core_handshake: got %0d violations required 0", name, core_err);
    end
  endtask

  logic [W-1:0] cur_key;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (avm_read !== 1'b0) begin miscompares++; $display("FAIL reset avm_read: got %b required 0", avm_read); end
    vectors++; if (avm_write !== 1'b0) begin miscompares++; $display("FAIL reset avm_write: got %b required 0", avm_write); end
    vectors++; if (avm_address !== 5'd8) begin miscompares++; $display("FAIL reset avm_address: got %0d required 8", avm_address); end
    vectors++; if (avm_writedata !== 32'h0) begin miscompares++; $display("FAIL reset avm_writedata: got %h required 0", avm_writedata); end
    vectors++; if (core_start !== 1'b0) begin miscompares++; $display("FAIL reset core_start: got %b required 0", core_start); end
    vectors++; if (core_x_out !== '0) begin miscompares++; $display("FAIL reset core_x: got %h required 0", core_x_out); end
    vectors++; if (core_y_out !== '0) begin miscompares++; $display("FAIL reset core_y: got %h required 0", core_y_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_key_data_load();
    logic [W-1:0] key, data;
    ws_max = 0; rx_hold_cfg = 0; tx_hold_cfg = 0;
    for (int i = 0; i < NB; i++) begin
      key  = (key << 8) | W'(i + 1);
      data = (data << 8) | W'(8'hA0 + i);
    end
    cur_key = key;
    run_block(key, data, 1'b1, "key_data_load");
  endtask

  task automatic test_waitrequest_stalls();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ws_max  = 4;
    cur_key = rand_word();
    run_block(cur_key, rand_word(), 1'b1, "waitrequest_stalls");
  endtask

  task automatic test_not_ready();
    int s0, need;
    ws_max = 2; rx_hold_cfg = 10; tx_hold_cfg = 7;
    s0 = status_reads;
    run_block(cur_key, rand_word(), 1'b0, "not_ready");
    need = (NB - 1) * (rx_hold_cfg + 1) + (OUT_BYTES - 1) * (tx_hold_cfg + 1);
    vectors++;
    if (status_reads - s0 < need) begin
      miscompares++;
      $display("FAIL not_ready status_polls: got %0d required at least %0d", status_reads - s0, need);
    end
    rx_hold_cfg = 0; tx_hold_cfg = 0;
  endtask

  task automatic test_second_block();
    ws_max = 3;
    run_block(cur_key, rand_word(), 1'b0, "second_block");
    ws_max = 1;
    run_block(cur_key, rand_word(), 1'b0, "back_to_back");
  endtask

  task automatic test_reset_during_wait();
    int s0, t0, n;
    core_auto = 1'b0; ws_max = 0;
    s0 = start_cnt; t0 = tx_cnt; n = 0;
    push_word(rand_word());
    while (start_cnt == s0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (start_cnt != s0 + 1) begin
      miscompares++;
      $display("FAIL reset_wait start: got %0d pulses required 1", start_cnt - s0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (core_y_out !== '0 || core_x_out !== '0) begin
      miscompares++;
      $display("FAIL reset_wait operands: got x=%h y=%h required 0", core_x_out, core_y_out);
    end
    repeat (5) @(negedge clk);
    spur_req++;
    repeat (60) @(negedge clk);
    vectors++;
    if (tx_cnt !== t0) begin
      miscompares++;
      $display("FAIL reset_wait tx_writes: got %0d required 0", tx_cnt - t0);
    end
    vectors++;
    if (start_cnt !== s0 + 1) begin
      miscompares++;
      $display("FAIL reset_wait extra_start: got %0d pulses required 1", start_cnt - s0);
    end
    core_auto = 1'b1;
    ws_max    = 2;
    cur_key   = rand_word();
    run_block(cur_key, rand_word(), 1'b1, "reload_after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_key_data_load();
    test_waitrequest_stalls();
    test_not_ready();
    test_second_block();
    test_reset_during_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rsa256_host_ctrl.md
# rsa256_host_ctrl

Host-side controller for the RSA256 core: the initiator on the core's start/finished interface. It pulls bytes from the RS232 UART over an Avalon-MM master port and assembles a 256-bit key word and successive 256-bit data words. For each data word it starts the core, waits for `finished`, and streams the result bytes back out through the same UART. It sits between the Qsys UART and the core in the top-level wrapper.

## Interface
Parameters:
- `W`, 256: core operand width; must be a multiple of 8.
- `OUT_BYTES`, 31: number of result bytes transmitted per block, taken from the low end of the result, most significant byte first.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `avm_address`  out  5  UART register address.
- `avm_read`  out  1  Avalon read request.
- `avm_readdata`  in  32  Avalon read data.
- `avm_write`  out  1  Avalon write request.
- `avm_writedata`  out  32  Avalon write data; only bits [7:0] are meaningful.
- `avm_waitrequest`  in  1  slave stall.
- `o_core_start`  out  1  one-cycle start pulse to the core.
- `o_core_x`  out  W  data operand to the core.
- `o_core_y`  out  W  key operand to the core.
- `i_core_x`  in  W  core result.
- `i_core_finished`  in  1  core done strobe.

## Operation
- UART register map: RX=0, TX=4, STATUS=8. Status bit 7 = RX ready (RX_OK), bit 6 = TX ready (TX_OK).
- State machine:
  - `RX_POLL`: read STATUS. If RX_OK=1, go to `RX_READ`; otherwise stay.
  - `RX_READ`: read RX, then shift the byte in: `reg <= {reg[W-9:0], rd[7:0]}`. Increment the byte counter.
    - Counter < W/8-1: return to `RX_POLL`.
    - Counter = W/8-1 with the key not yet loaded: the target register was `o_core_y`. Set `key_loaded`, clear the counter, go to `RX_POLL`.
    - Counter = W/8-1 with the key loaded: the target was `o_core_x`. Go to `START`.
  - `START`: assert `o_core_start` for exactly 1 cycle, then go to `WAIT`.
  - `WAIT`: when `i_core_finished`=1, latch `i_core_x` into the result shift register, clear the counter, go to `TX_POLL`.
  - `TX_POLL`: read STATUS. If TX_OK=1, go to `TX_WRITE`.
  - `TX_WRITE`: write result byte [8·OUT_BYTES-1 -: 8] to TX, then shift the result left by 8.
    - If OUT_BYTES bytes have been sent, clear the counter and go to `RX_POLL` (next data word; the key is retained).
    - Otherwise go to `TX_POLL`.
- Avalon rules:
  - At most one of read or write is asserted at a time.
  - The request, address and writedata are held stable while `avm_waitrequest`=1.
  - A transfer completes in the cycle where the request is high and waitrequest=0. Readdata is sampled in that cycle, and the request deasserts on the next cycle.
  - There is no back-to-back request without at least one deasserted cycle between them.
- `i_core_finished` outside `WAIT` is ignored.
- The key is reloaded only after reset.

## Timing
- Reset values:
  - `avm_read`=0, `avm_write`=0, `avm_address`=8, `avm_writedata`=0.
  - `o_core_start`=0, `o_core_x`=0, `o_core_y`=0.
  - State `RX_POLL`, `key_loaded`=0, counter 0.
- Each UART byte costs at least 2 Avalon transfers (status, then data). With zero wait states and an immediately ready status, one byte takes 4 cycles.
- `o_core_start` rises 1 cycle after the cycle in which the last data byte transfer completes.
- `o_core_x` and `o_core_y` are stable from the start pulse until the result is latched.
- The result is latched in the same cycle `i_core_finished` is seen; `avm_read` of STATUS begins on the next cycle.
- Reset mid-operation: any cycle with `i_rst_n`=0 restores all reset values on the next edge, abandoning an in-flight Avalon request and a pending core run.
- Counter width is ceil(log2(W/8)). There is no wrap-around beyond W/8-1.

## Structure
- Shared package `rsa256_pkg` holds:
  - the RX/TX/STATUS address constants;
  - the RX_OK/TX_OK bit indices;
  - the `host_state_t` enum.
- Sub-module `rsa256_avm_access` performs a single Avalon read or write with the waitrequest hold and returns a `done` pulse plus read data. The FSM and shift registers stay in `rsa256_host_ctrl`.

## Test plan
- Reset: hold `i_rst_n`=0 for 3 cycles -> all outputs at reset values, `avm_address`=8, no requests.
- Key and data load: feed key bytes 0x01..0x20, then data bytes 0xA0..0xBF, with zero wait states. A stub core returns x^y after 5 cycles.
  - `o_core_y`=0x0102…20.
  - `o_core_x`=0xA0A1…BF.
  - `o_core_start` is exactly one pulse.
  - 31 TX writes of the low 31 bytes of x^y, MSB first.
- Waitrequest stalls: random 0–4 cycle waitrequest on every transfer -> request, address and writedata are stable during the stall, with no dropped or duplicated bytes.
- Not ready: STATUS returns 0x00 for 10 polls before RX_OK=1, and TX_OK is withheld for 7 polls -> the block polls repeatedly and the byte stream is unchanged.
- Second block: feed another 32 data bytes after the first result -> the key is not reloaded, a second start pulse occurs, and the second result is transmitted.
- Reset during `WAIT`, then a spurious `i_core_finished`:
  - no TX write;
  - the block restarts at `RX_POLL` with `key_loaded`=0;
  - `i_core_finished` pulsed while in `RX_POLL` is ignored.
